ucaspian_neuron_arb: RTL and testbench
======================================

// Module: ucaspian_neuron_arb
// PURPOSE
//  Shares the single dendrite->neuron charge port between NUM_REQ charge
//  requesters, e.g. synapse pipelines and the host input injector.
//  Uses a round-robin grant into a one-entry output register.
//  Also sequences the time step: opens grants on next_step, then closes the
//  step once all requesters are done and the neuron reports idle.
//  Sits between the requesters and ucaspian_neuron (neuron_* and step_done).
// PARAMETERS
//  NUM_REQ   4   number of charge requesters (2..8)
//  ADDR_W    8   neuron address width
//  CHARGE_W  16  signed charge width
// PORTS
//  clk               in   1                  clock; all logic on posedge
//  reset             in   1                  synchronous, active-low reset (0 = reset)
//  enable            in   1                  0 freezes FSM and grants; output reg holds
//  next_step         in   1                  start-of-step pulse
//  step_done         out  1                  1-cycle pulse: step fully drained
//  req_addr          in   NUM_REQ*ADDR_W     per-requester target neuron, packed [i]
//  req_charge        in   NUM_REQ*CHARGE_W   per-requester signed charge, packed [i]
//  req_vld           in   NUM_REQ            request valid
//  req_rdy           out  NUM_REQ            grant; at most one bit set per cycle
//  req_done          in   NUM_REQ            requester has no more work this step (level)
//  neuron_addr       out  ADDR_W             to neuron
//  neuron_charge     out  CHARGE_W           to neuron, signed
//  neuron_vld        out  1                  to neuron
//  neuron_rdy        in   1                  from neuron
//  neuron_step_done  in   1                  neuron idle indication (registered in neuron)
// BEHAVIOUR
//  Reset: neuron_vld=0, neuron_addr=0, neuron_charge=0, req_rdy=0,
//   step_done=0, FSM=IDLE, rr_last=NUM_REQ-1. Mid-operation reset discards
//   the held entry with no handshake.
//  Transfer rule: a transfer happens on any cycle with vld&rdy high.
//   neuron_vld, once set, holds with stable data until neuron_rdy.
//  slot_free = ~neuron_vld | neuron_rdy.
//  Grants are issued only when FSM=RUN, enable=1 and slot_free.
//  Grant order: first i with req_vld[i], searching from rr_last+1 mod NUM_REQ.
//   req_rdy[i] is combinational from that search. rr_last<=i on grant.
//  Latency: accepted request appears on neuron_* the next cycle.
//   Throughput is 1/cycle while neuron_rdy=1.
//  Charge is passed unmodified at full CHARGE_W; no truncation.
//  FSM:
//   IDLE: next_step -> RUN.
//   RUN: next_step ignored. When &req_done & ~|req_vld & ~neuron_vld -> WAIT.
//   WAIT: 2-cycle settle counter first (covers the neuron's registered
//    step_done). Then neuron_step_done=1 -> DONE.
//   DONE: step_done=1 for one cycle -> IDLE.
//   A next_step arriving in WAIT or DONE is dropped.
//  enable=0: FSM state, counter and rr_last hold; req_rdy=0.
//   neuron_vld may still complete a pending transfer.
// CONFIGURATION
//  UCASPIAN_ARB_MERGE_EN defined:
//   In RUN with neuron_vld=1, neuron_rdy=0 and a granted-candidate request
//   whose addr equals neuron_addr, that request is accepted and merged:
//   neuron_charge <= sat(neuron_charge + req_charge).
//   Saturation is to [-2^(CHARGE_W-1), 2^(CHARGE_W-1)-1], computed at
//   CHARGE_W+1 bits. The merged entry counts as the grant for rr_last.
//  UCASPIAN_ARB_MERGE_EN not defined: no merging; a stalled slot blocks all
//   grants.
// STRUCTURE
//  ucaspian_pkg: typedef logic [ADDR_W-1:0] neuron_addr_t;
//   typedef logic signed [CHARGE_W-1:0] charge_t;
//   typedef enum {IDLE,RUN,WAIT,DONE} arb_state_t; localparam SETTLE_CYC=2.
//  Sub-module ucaspian_rr_pick: combinational rotate-priority find-first
//   (req, last) -> (onehot, idx, any).
// TESTING
//  1. All 4 req_vld=1 in RUN with neuron_rdy=1: grant order 0,1,2,3,0.
//     neuron_vld follows each grant by 1 cycle, no gaps.
//  2. neuron_rdy=0 for 5 cycles with entry addr=3, charge=-7: req_rdy stays 0
//     and neuron_* stays stable; release -> exactly one transfer.
//  3. Step sequence: next_step, then all req_done=1, neuron_step_done=1.
//     step_done pulses exactly once, >=3 cycles after the last transfer.
//     A second next_step in WAIT is ignored.
//  4. reset=0 asserted while neuron_vld=1 in RUN: next cycle neuron_vld=0,
//     FSM=IDLE; grant order restarts at requester 0.
//  5. MERGE_EN, stalled entry addr=5, charge=32000; req addr=5, charge=1000:
//     neuron_charge=32767. Unstalled, the same case gives 2 transfers.
//  6. enable=0 in RUN with req_vld=4'b1111: no req_rdy, FSM holds;
//     enable=1 resumes from the saved rr_last.

Source files
------------

// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared types and constants for the neuron charge arbiter
package ucaspian_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_CHARGE_W = 16;
    localparam int SETTLE_CYC   = 2;

    typedef logic [DEF_ADDR_W-1:0]          neuron_addr_t;
    typedef logic signed [DEF_CHARGE_W-1:0] charge_t;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} arb_state_t;

endpackage

// File: rtl/ucaspian_rr_pick.sv
// ucaspian_rr_pick: rotate-priority find-first starting one past the last winner
module ucaspian_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requesters from last+1 around to last and keep the first hit
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last) + k) % N]) begin
                any                           = 1'b1;
                idx                           = IW'((int'(last) + k) % N);
                onehot[(int'(last) + k) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ucaspian_neuron_arb.sv
// ucaspian_neuron_arb: round-robin charge arbiter into the neuron port plus time-step sequencer
// Optional same-address charge merging into a stalled entry: UCASPIAN_ARB_MERGE_EN
module ucaspian_neuron_arb
    import ucaspian_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 8,
    parameter int CHARGE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         next_step,
    output logic                         step_done,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*CHARGE_W-1:0]  req_charge,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    input  logic [NUM_REQ-1:0]           req_done,
    output logic [ADDR_W-1:0]            neuron_addr,
    output logic [CHARGE_W-1:0]          neuron_charge,
    output logic                         neuron_vld,
    input  logic                         neuron_rdy,
    input  logic                         neuron_step_done
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t                  state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [IW-1:0]               rr_last_q, rr_last_d;
    logic                        vld_q, vld_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic signed [CHARGE_W-1:0]  charge_q, charge_d;

    logic [NUM_REQ-1:0]          pick_oh;
    logic [IW-1:0]               pick_idx;
    logic                        pick_any;
    logic [ADDR_W-1:0]           cand_addr;
    logic signed [CHARGE_W-1:0]  cand_charge;
    logic signed [CHARGE_W-1:0]  sat_charge;
    logic                        slot_free, grant_en, merge_en, take;

    ucaspian_rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req_vld),
        .last   (rr_last_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Candidate payload and the slot/grant qualifiers
    always_comb begin
        cand_addr   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        cand_charge = req_charge[int'(pick_idx)*CHARGE_W +: CHARGE_W];
        slot_free   = !vld_q || neuron_rdy;
        grant_en    = state_q == RUN && enable && slot_free;
        take        = grant_en && pick_any;
    end

`ifdef UCASPIAN_ARB_MERGE_EN
    logic signed [CHARGE_W:0] sum;

    // Fold a same-address candidate into the stalled entry, saturating one bit wider
    always_comb begin
        sum        = {charge_q[CHARGE_W-1], charge_q} + {cand_charge[CHARGE_W-1], cand_charge};
        sat_charge = (sum[CHARGE_W] != sum[CHARGE_W-1])
                   ? (sum[CHARGE_W] ? {1'b1, {(CHARGE_W-1){1'b0}}} : {1'b0, {(CHARGE_W-1){1'b1}}})
                   : sum[CHARGE_W-1:0];
        merge_en   = state_q == RUN && enable && vld_q && !neuron_rdy && pick_any && cand_addr == addr_q;
    end
`else
    // Without merging a stalled entry simply blocks every grant
    always_comb begin
        sat_charge = charge_q;
        merge_en   = 1'b0;
    end
`endif

    // Grant, output register and round-robin pointer next state
    always_comb begin
        req_rdy   = (grant_en || merge_en) ? pick_oh : '0;
        vld_d     = take ? 1'b1 : (neuron_rdy ? 1'b0 : vld_q);
        addr_d    = take ? cand_addr : addr_q;
        charge_d  = take ? cand_charge : (merge_en ? sat_charge : charge_q);
        rr_last_d = (take || merge_en) ? pick_idx : rr_last_q;
    end

    // Step sequencer: open on next_step, drain, settle for the neuron's registered idle, pulse done
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_done = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: state_d = next_step ? RUN : IDLE;
                RUN: begin
                    if (&req_done && !(|req_vld) && !vld_q) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'(SETTLE_CYC))
                        cnt_d = cnt_q + 2'd1;
                    else if (neuron_step_done)
                        state_d = DONE;
                end
                DONE: begin
                    step_done = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset drops any held entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= IW'(NUM_REQ - 1);
            vld_q     <= 1'b0;
            addr_q    <= '0;
            charge_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            vld_q     <= vld_d;
            addr_q    <= addr_d;
            charge_q  <= charge_d;
        end
    end

    assign neuron_vld    = vld_q;
    assign neuron_addr   = addr_q;
    assign neuron_charge = charge_q;

endmodule

// File: tb/tb_ucaspian_neuron_arb.sv
// tb_ucaspian_neuron_arb: directed self-checking bench for the neuron charge arbiter
module tb_ucaspian_neuron_arb;
    import ucaspian_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, next_step, step_done;
    logic [31:0] req_addr;
    logic [63:0] req_charge;
    logic [3:0]  req_vld, req_rdy, req_done;
    logic [7:0]  neuron_addr;
    logic [15:0] neuron_charge;
    logic        neuron_vld, neuron_rdy, neuron_step_done;

    int pass_cnt = 0;
    int total    = 0;

    ucaspian_neuron_arb #(.NUM_REQ(4), .ADDR_W(8), .CHARGE_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .next_step        (next_step),
        .step_done        (step_done),
        .req_addr         (req_addr),
        .req_charge       (req_charge),
        .req_vld          (req_vld),
        .req_rdy          (req_rdy),
        .req_done         (req_done),
        .neuron_addr      (neuron_addr),
        .neuron_charge    (neuron_charge),
        .neuron_vld       (neuron_vld),
        .neuron_rdy       (neuron_rdy),
        .neuron_step_done (neuron_step_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_step;
        next_step = 1'b1;
        tick();
        next_step = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; next_step = 1'b0; req_vld = 4'hf; req_done = 4'h0;
        neuron_rdy = 1'b1; neuron_step_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*8 +: 8]    = 8'h10 + 8'(i);
            req_charge[i*16 +: 16] = 16'(i * 100);
        end
        tick(); tick();
        total++; if (neuron_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", neuron_vld); else pass_cnt++;
        total++; if (neuron_addr !== 8'h00) $display("FAIL reset_addr got=%h exp=00", neuron_addr); else pass_cnt++;
        total++; if (neuron_charge !== 16'h0000) $display("FAIL reset_charge got=%h exp=0000", neuron_charge); else pass_cnt++;
        total++; if (req_rdy !== 4'b0000) $display("FAIL reset_rdy got=%b exp=0000", req_rdy); else pass_cnt++;
        total++; if (step_done !== 1'b0) $display("FAIL reset_step_done got=%b exp=0", step_done); else pass_cnt++;
        total++; if (dut.state_q !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
        total++; if (dut.rr_last_q !== 2'd3) $display("FAIL reset_rr_last got=%0d exp=3", dut.rr_last_q); else pass_cnt++;
        reset = 1'b1; req_vld = 4'h0;
        tick();
    endtask

    task automatic test_rr_order;
        int g;
        start_step();
        req_vld = 4'hf; neuron_rdy = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            total++; if (req_rdy !== 4'(1 << g)) $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, 4'(1 << g)); else pass_cnt++;
            tick();
            total++; if (neuron_vld !== 1'b1 || neuron_addr !== 8'h10 + 8'(g))
                $display("FAIL rr_out k=%0d got vld=%b addr=%h exp vld=1 addr=%h", k, neuron_vld, neuron_addr, 8'h10 + 8'(g));
            else pass_cnt++;
        end
        req_vld = 4'h0;
        tick();
        total++; if (neuron_vld !== 1'b0) $display("FAIL rr_drain got=%b exp=0", neuron_vld); else pass_cnt++;
    endtask

    task automatic test_stall;
        req_addr[1*8 +: 8] = 8'd3; req_charge[1*16 +: 16] = 16'hfff9;
        req_vld = 4'b0010; neuron_rdy = 1'b0;
        #1;
        total++; if (req_rdy !== 4'b0010) $display("FAIL stall_load got=%b exp=0010", req_rdy); else pass_cnt++;
        tick();
        req_vld = 4'hf;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_rdy !== 4'b0000 || neuron_vld !== 1'b1 || neuron_addr !== 8'd3 || neuron_charge !== 16'hfff9)
                $display("FAIL stall_hold k=%0d got rdy=%b vld=%b addr=%h chg=%h exp rdy=0000 vld=1 addr=03 chg=fff9",
                         k, req_rdy, neuron_vld, neuron_addr, neuron_charge);
            else pass_cnt++;
            tick();
        end
        req_vld = 4'h0; neuron_rdy = 1'b1;
        tick();
        total++; if (neuron_vld !== 1'b0) $display("FAIL stall_release got=%b exp=0", neuron_vld); else pass_cnt++;
    endtask

    task automatic test_step;
        int first, pulses;
        first = -1; pulses = 0;
        req_vld = 4'b0001; neuron_rdy = 1'b1;
        #1;
        tick();
        req_vld = 4'h0; req_done = 4'hf; neuron_step_done = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) begin
                total++; if (dut.state_q !== WAIT) $display("FAIL step_wait got=%0d exp=%0d", dut.state_q, WAIT); else pass_cnt++;
                next_step = 1'b1;
            end
            if (c == 4) next_step = 1'b0;
            if (step_done === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        total++; if (first !== 5) $display("FAIL step_latency got=%0d exp=5", first); else pass_cnt++;
        total++; if (pulses !== 1) $display("FAIL step_pulses got=%0d exp=1", pulses); else pass_cnt++;
        total++; if (dut.state_q !== IDLE) $display("FAIL step_end_state got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
        req_done = 4'h0; neuron_step_done = 1'b0;
    endtask

    task automatic test_mid_reset;
        start_step();
        req_vld = 4'hf; neuron_rdy = 1'b0;
        #1;
        tick();
        total++; if (neuron_vld !== 1'b1) $display("FAIL mreset_pre got=%b exp=1", neuron_vld); else pass_cnt++;
        reset = 1'b0;
        tick();
        total++; if (neuron_vld !== 1'b0 || neuron_addr !== 8'h00) $display("FAIL mreset_out got vld=%b addr=%h exp vld=0 addr=00", neuron_vld, neuron_addr); else pass_cnt++;
        total++; if (dut.state_q !== IDLE) $display("FAIL mreset_state got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
        reset = 1'b1; neuron_rdy = 1'b1;
        start_step();
        #1;
        total++; if (req_rdy !== 4'b0001) $display("FAIL mreset_restart got=%b exp=0001", req_rdy); else pass_cnt++;
        req_vld = 4'h0;
        tick();
    endtask

    task automatic test_merge;
        int xfers;
        logic [3:0] g;
        xfers = 0;
        req_addr[1*8 +: 8] = 8'd5; req_charge[1*16 +: 16] = 16'd32000;
        req_vld = 4'b0010; neuron_rdy = 1'b0;
        #1;
        tick();
        req_addr[2*8 +: 8] = 8'd5; req_charge[2*16 +: 16] = 16'd1000;
        req_vld = 4'b0100;
        #1;
`ifdef UCASPIAN_ARB_MERGE_EN
        total++; if (req_rdy !== 4'b0100) $display("FAIL merge_grant got=%b exp=0100", req_rdy); else pass_cnt++;
        tick();
        req_vld = 4'h0;
        #1;
        total++; if (neuron_charge !== 16'h7fff || neuron_vld !== 1'b1 || neuron_addr !== 8'd5)
            $display("FAIL merge_sat got chg=%h vld=%b addr=%h exp chg=7fff vld=1 addr=05", neuron_charge, neuron_vld, neuron_addr);
        else pass_cnt++;
`else
        total++; if (req_rdy !== 4'b0000) $display("FAIL nomerge_block got=%b exp=0000", req_rdy); else pass_cnt++;
        tick();
        req_vld = 4'h0;
        #1;
        total++; if (neuron_charge !== 16'd32000 || neuron_vld !== 1'b1)
            $display("FAIL nomerge_hold got chg=%h vld=%b exp chg=7d00 vld=1", neuron_charge, neuron_vld);
        else pass_cnt++;
`endif
        neuron_rdy = 1'b1;
        tick();
        req_vld = 4'b0110;
        for (int c = 0; c < 6; c++) begin
            #1;
            g = req_rdy;
            if (neuron_vld && neuron_rdy) xfers++;
            tick();
            req_vld = req_vld & ~g;
        end
        total++; if (xfers !== 2) $display("FAIL merge_unstalled_xfers got=%0d exp=2", xfers); else pass_cnt++;
    endtask

    task automatic test_enable;
        req_vld = 4'b0001; neuron_rdy = 1'b1;
        #1;
        tick();
        enable = 1'b0; req_vld = 4'hf;
        #1;
        total++; if (req_rdy !== 4'b0000) $display("FAIL en_rdy0 got=%b exp=0000", req_rdy); else pass_cnt++;
        tick();
        total++; if (neuron_vld !== 1'b0) $display("FAIL en_drain got=%b exp=0", neuron_vld); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            total++; if (req_rdy !== 4'b0000 || dut.state_q !== RUN || dut.rr_last_q !== 2'd0)
                $display("FAIL en_hold k=%0d got rdy=%b state=%0d rr=%0d exp rdy=0000 state=%0d rr=0", k, req_rdy, dut.state_q, dut.rr_last_q, RUN);
            else pass_cnt++;
            tick();
        end
        enable = 1'b1;
        #1;
        total++; if (req_rdy !== 4'b0010) $display("FAIL en_resume got=%b exp=0010", req_rdy); else pass_cnt++;
        req_vld = 4'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_stall();
        test_step();
        test_mid_reset();
        test_merge();
        test_enable();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total);
        $fatal(1, "timeout");
    end

endmodule
